// File: rtl/ucie_ctl_rx_flow_buffer_if.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_flow_buffer_if
//
// Bundles the flit-carrying signals of the receive flow buffer: the RDI
// receive side (data + valid, no backpressure) and the FDI side
// (data + valid out, ready in).
//
// Handshake: a flit moves across the FDI side on every rising clock edge
// where fdi_data_valid and fdi_ready are both 1. fdi_data_valid does not
// depend combinationally on fdi_ready, and once raised it stays up (with
// fdi_data stable) until that transfer happens, unless a flush or reset
// discards the flit. The RDI side has no ready: a flit is offered on every
// edge where rdi_pl_valid is 1.
//
// Modports:
//   slave  - the buffer: receives RDI data/valid and FDI ready,
//            drives FDI data/valid.
//   master - the environment around the buffer (RDI producer and FDI
//            consumer together).
// ---------------------------------------------------------------------------
interface ucie_ctl_rx_flow_buffer_if #(
  parameter int W = 64
);
  logic [W-1:0] rdi_pl_data;
  logic         rdi_pl_valid;
  logic [W-1:0] fdi_data;
  logic         fdi_data_valid;
  logic         fdi_ready;

  modport slave (
    input  rdi_pl_data,
    input  rdi_pl_valid,
    input  fdi_ready,
    output fdi_data,
    output fdi_data_valid
  );

  modport master (
    output rdi_pl_data,
    output rdi_pl_valid,
    output fdi_ready,
    input  fdi_data,
    input  fdi_data_valid
  );
endinterface

// File: rtl/ucie_ctl_rx_flow_buffer.sv
// ---------------------------------------------------------------------------
// ucie_ctl_rx_flow_buffer
//
// Receive-side elastic buffer between the RDI receive datapath and the FDI
// data interface. Every valid RDI flit (while enabled) is captured into a
// DEPTH-entry circular FIFO; the FIFO head is presented through a registered
// output stage with a valid/ready handshake. When the FIFO is empty and the
// output stage is free, an incoming flit bypasses the FIFO and lands in the
// output register directly, giving one cycle of latency. Total capacity is
// DEPTH+1 flits (FIFO plus output register).
//
// Parameters:
//   NBYTES       - flit width in bytes (data width W = NBYTES*8)
//   DEPTH        - FIFO entries, power of two, >= 2
//   AFULL_THRESH - occupancy at which o_almost_full asserts, 1..DEPTH
//
// Ports:
//   i_clk               clock
//   i_rst               asynchronous active-low reset
//   bus                 RDI data/valid in, FDI data/valid out, FDI ready in
//   i_buffer_en         enables capture and output refill
//   i_flush             synchronous flush (highest priority)
//   i_ovf_clr           clears overflow flag and drop counter
//   o_count             FIFO occupancy (output register not included)
//   o_empty             o_count == 0
//   o_full              o_count == DEPTH
//   o_almost_full       o_count >= AFULL_THRESH
//   o_overflow_detected sticky: at least one flit dropped
//   o_drop_count        dropped flits, saturating at 255
//
// All outputs come straight from registers or are decoded from registered
// state only; there is no input-to-output combinational path. Note that
// o_empty is a decode of the count, so it reads 1 while in reset.
// ---------------------------------------------------------------------------
module ucie_ctl_rx_flow_buffer #(
  parameter int NBYTES       = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int W           = NBYTES * 8,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  ucie_ctl_rx_flow_buffer_if.slave   bus,
  input  logic                       i_buffer_en,
  input  logic                       i_flush,
  input  logic                       i_ovf_clr,
  output logic [CW-1:0]              o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_overflow_detected,
  output logic [7:0]                 o_drop_count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          ovf_q;
  logic [7:0]    drop_q;

  // -------------------------------------------------------------------------
  // Per-cycle decisions
  // -------------------------------------------------------------------------
  logic push;
  logic pop;
  logic stage_free;
  logic fifo_nonempty;
  logic refill_en;
  logic fifo_rd;
  logic bypass;
  logic fifo_room;
  logic fifo_wr;
  logic drop;

  always_comb begin
    push          = i_buffer_en & bus.rdi_pl_valid;
    pop           = valid_q & bus.fdi_ready;
    stage_free    = ~valid_q | pop;
    fifo_nonempty = (count_q != '0);
    refill_en     = i_buffer_en & stage_free;

    // The FIFO head always takes priority over a new flit, so bypass only
    // happens with an empty FIFO and ordering stays strictly FIFO.
    fifo_rd       = refill_en & fifo_nonempty;
    bypass        = refill_en & ~fifo_nonempty & push;

    // A full FIFO still accepts a write when its head leaves in the same
    // cycle; that is what lets push+pop at count==DEPTH run without drops.
    fifo_room     = (count_q < DEPTH_C) | fifo_rd;
    fifo_wr       = push & ~bypass & fifo_room;
    drop          = push & ~bypass & ~fifo_room;
  end

  // -------------------------------------------------------------------------
  // Storage array: not reset, contents are only meaningful behind count_q.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (fifo_wr && !i_flush) begin
      mem[wr_ptr_q] <= bus.rdi_pl_data;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (fifo_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output register. Flush drops the valid bit but leaves the data, so
  // o_fdi_data always shows the last flit loaded.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (refill_en) begin
      // Stage free and enabled: load the head, bypass the input, or go idle.
      if (fifo_rd) begin
        data_q  <= mem[rd_ptr_q];
        valid_q <= 1'b1;
      end else if (bypass) begin
        data_q  <= bus.rdi_pl_data;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (pop) begin
      // Disabled buffer: a pending flit can still leave, but nothing refills.
      valid_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Overflow flag and drop counter. A drop in the same cycle as a clear
  // wins, so the event is never lost: the counter restarts at 1.
  // Drops are not recorded during a flush since the push is discarded.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop && !i_flush) begin
      ovf_q <= 1'b1;
      if (i_ovf_clr) begin
        drop_q <= 8'd1;
      end else if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end else if (i_ovf_clr) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.fdi_data         = data_q;
  assign bus.fdi_data_valid   = valid_q;
  assign o_count              = count_q;
  assign o_empty              = (count_q == '0);
  assign o_full               = (count_q == DEPTH_C);
  assign o_almost_full        = (count_q >= AFULL_C);
  assign o_overflow_detected  = ovf_q;
  assign o_drop_count         = drop_q;

endmodule

// File: tb/tb_ucie_ctl_rx_flow_buffer.sv
// ---------------------------------------------------------------------------
// tb_ucie_ctl_rx_flow_buffer
//
// Directed bench for the receive flow buffer with DEPTH=4, AFULL_THRESH=3,
// 64-bit flits. Inputs are driven and outputs sampled 1 time unit after the
// rising edge; every expected value below is worked out by hand from the
// buffer's intended behaviour.
// ---------------------------------------------------------------------------
module tb_ucie_ctl_rx_flow_buffer;

  localparam int NBYTES = 8;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int W      = NBYTES * 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  // Clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_buffer_en = 1'b0;
  logic          i_flush     = 1'b0;
  logic          i_ovf_clr   = 1'b0;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_almost_full;
  logic          o_overflow_detected;
  logic [7:0]    o_drop_count;

  ucie_ctl_rx_flow_buffer_if #(.W(W)) bus ();

  ucie_ctl_rx_flow_buffer #(
    .NBYTES       (NBYTES),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .bus                 (bus),
    .i_buffer_en         (i_buffer_en),
    .i_flush             (i_flush),
    .i_ovf_clr           (i_ovf_clr),
    .o_count             (o_count),
    .o_empty             (o_empty),
    .o_full              (o_full),
    .o_almost_full       (o_almost_full),
    .o_overflow_detected (o_overflow_detected),
    .o_drop_count        (o_drop_count)
  );

  int vectors = 0;
  int errs    = 0;

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [W-1:0] d, input logic rdy);
    bus.rdi_pl_valid = vld;
    bus.rdi_pl_data  = d;
    bus.fdi_ready    = rdy;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_valid", W'(bus.fdi_data_valid), 0);
    check("rst_data",  bus.fdi_data, 0);
    check("rst_count", W'(o_count), 0);
    check("rst_empty", W'(o_empty), 1);
    check("rst_full",  W'(o_full), 0);
    check("rst_ovf",   W'(o_overflow_detected), 0);
    check("rst_drops", W'(o_drop_count), 0);
    i_rst = 1'b1;
    i_buffer_en = 1'b1;
    tick();

    // ---------------- single bypass flit ----------------
    drive(1'b1, 64'hA5, 1'b1);
    tick();
    check("byp_valid", W'(bus.fdi_data_valid), 1);
    check("byp_data",  bus.fdi_data, 64'hA5);
    check("byp_count", W'(o_count), 0);
    drive(1'b0, '0, 1'b1);
    tick();
    check("byp_drain", W'(bus.fdi_data_valid), 0);

    // ---------------- fill to capacity, then overflow ----------------
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
      if (i == 1) check("fill_cnt1", W'(o_count), 0);
      if (i == 2) check("fill_af2",  W'(o_almost_full), 0);
      if (i == 3) check("fill_af3",  W'(o_count), 2);
      if (i == 4) check("fill_af4",  W'(o_almost_full), 1);
      if (i == 5) check("fill_full", W'(o_full), 1);
    end
    check("ovf_flag",  W'(o_overflow_detected), 1);
    check("ovf_drops", W'(o_drop_count), 1);
    check("ovf_count", W'(o_count), 4);
    check("ovf_head",  bus.fdi_data, 1);
    drive(1'b0, '0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("drain_data",  bus.fdi_data, W'(i));
      check("drain_valid", W'(bus.fdi_data_valid), 1);
      if (i == 3) check("drain_af_off", W'(o_almost_full), 0);
    end
    check("drain_empty", W'(o_empty), 1);
    tick();
    check("drain_done", W'(bus.fdi_data_valid), 0);

    // ---------------- full FIFO, push+pop every cycle ----------------
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
    end
    check("strm_pre_cnt", W'(o_count), 4);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, W'(5 + k), 1'b1);
      tick();
      check("strm_data",  bus.fdi_data, W'(1 + k));
      check("strm_count", W'(o_count), 4);
    end
    check("strm_drops", W'(o_drop_count), 1);
    drive(1'b0, '0, 1'b1);
    for (int i = 12; i <= 15; i++) begin
      tick();
      check("strm_tail", bus.fdi_data, W'(i));
    end
    tick();
    check("strm_end", W'(bus.fdi_data_valid), 0);

    // ---------------- flush with simultaneous push ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(32'h21 + i), 1'b0);
      tick();
    end
    check("fl_pre_cnt", W'(o_count), 3);
    drive(1'b1, 64'h25, 1'b1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl_count", W'(o_count), 0);
    check("fl_valid", W'(bus.fdi_data_valid), 0);
    check("fl_ovf",   W'(o_overflow_detected), 1);
    check("fl_drops", W'(o_drop_count), 1);
    check("fl_data",  bus.fdi_data, 64'h21);
    drive(1'b1, 64'h77, 1'b1);
    tick();
    check("fl_new_v", W'(bus.fdi_data_valid), 1);
    check("fl_new_d", bus.fdi_data, 64'h77);
    drive(1'b0, '0, 1'b1);
    tick();

    // ---------------- drop counter saturation and clear ----------------
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    i_ovf_clr = 1'b1;
    tick();
    check("clr0_flag",  W'(o_overflow_detected), 0);
    check("clr0_drops", W'(o_drop_count), 0);
    i_ovf_clr = 1'b0;
    drive(1'b1, 64'hEE, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    check("sat_drops", W'(o_drop_count), 255);
    check("sat_flag",  W'(o_overflow_detected), 1);
    check("sat_count", W'(o_count), 4);
    drive(1'b0, '0, 1'b0);
    i_ovf_clr = 1'b1;
    tick();
    check("clr1_flag",  W'(o_overflow_detected), 0);
    check("clr1_drops", W'(o_drop_count), 0);
    drive(1'b1, 64'hEE, 1'b0);
    tick();
    i_ovf_clr = 1'b0;
    check("clr2_flag",  W'(o_overflow_detected), 1);
    check("clr2_drops", W'(o_drop_count), 1);

    // ---------------- buffer disabled: pop completes, no refill ----------------
    i_buffer_en = 1'b0;
    drive(1'b1, 64'h99, 1'b1);
    tick();
    check("dis_valid", W'(bus.fdi_data_valid), 0);
    check("dis_count", W'(o_count), 4);
    check("dis_drops", W'(o_drop_count), 1);
    i_buffer_en = 1'b1;
    drive(1'b0, '0, 1'b1);
    tick();
    check("en_valid", W'(bus.fdi_data_valid), 1);
    check("en_data",  bus.fdi_data, 2);
    check("en_count", W'(o_count), 3);

    // ---------------- asynchronous reset mid-transfer ----------------
    drive(1'b0, '0, 1'b0);
    #2;
    i_rst = 1'b0;
    #1;
    check("arst_valid", W'(bus.fdi_data_valid), 0);
    check("arst_count", W'(o_count), 0);
    check("arst_data",  bus.fdi_data, 0);
    check("arst_ovf",   W'(o_overflow_detected), 0);
    tick();
    i_rst = 1'b1;
    drive(1'b0, '0, 1'b1);
    tick();
    check("arst_idle", W'(bus.fdi_data_valid), 0);
    drive(1'b1, 64'h5A, 1'b1);
    tick();
    check("arst_new",  bus.fdi_data, 64'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
